// File: rtl/m65c02_mem_wait_ctrl.sv
// Memory-cycle controller: region decode, per-region wait states,
// core Rdy generation, registered read data and IO watchdog.
module m65c02_mem_wait_ctrl #(
   parameter int          pWS_RAM   = 0,
   parameter int          pWS_ROM   = 1,
   parameter int          pWS_IO    = 2,
   parameter logic [7:0]  pROM_PAGE = 8'hF0,
   parameter logic [7:0]  pIO_PAGE  = 8'hEF,
   parameter int          pTimeout  = 255
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [15:0] AO,
   input  logic [1:0]  IO_Op,
   input  logic [7:0]  DO,
   output logic        Rdy,
   output logic [7:0]  DI,
   output logic        BusErr,
   output logic [15:0] MA,
   output logic [7:0]  MD_O,
   input  logic [7:0]  MD_I,
   output logic        nRD,
   output logic        nWR,
   output logic [2:0]  nCS,
   input  logic        Wait_In
);

   localparam logic [3:0] WS_RAM = 4'(pWS_RAM);
   localparam logic [3:0] WS_ROM = 4'(pWS_ROM);
   localparam logic [3:0] WS_IO  = 4'(pWS_IO);
   localparam logic [7:0] TMO    = 8'(pTimeout);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic [7:0]  tmo, tmo_nxt;
   logic [2:0]  cs_l, cs_l_nxt;
   logic [1:0]  op_l, op_l_nxt;
   logic [2:0]  cs_dec, cs_eff, cs_act;
   logic [1:0]  op_eff;
   logic [3:0]  ws_dec;
   logic        io_w;
   logic        rdy_c;
   logic        err_set;

   // Active-high one-hot region select; IO wins over ROM over RAM
   always_comb begin
      cs_dec = 3'b001;
      ws_dec = WS_RAM;
      if (AO[15:8] == pIO_PAGE) begin
         cs_dec = 3'b100;
         ws_dec = WS_IO;
      end else if (AO[15:8] >= pROM_PAGE) begin
         cs_dec = 3'b010;
         ws_dec = WS_ROM;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      tmo_nxt   = tmo;
      cs_l_nxt  = cs_l;
      op_l_nxt  = op_l;
      cs_eff    = cs_dec;
      op_eff    = IO_Op;
      io_w      = 1'b0;
      rdy_c     = 1'b0;
      err_set   = 1'b0;
      case (state)
         IDLE: begin
            if (IO_Op == 2'b00) begin
               rdy_c = 1'b1;
            end else if (ws_dec == 4'd0 && !cs_dec[2]) begin
               rdy_c = 1'b1;
            end else begin
               state_nxt = WAIT;
               cnt_nxt   = (ws_dec == 4'd0) ? 4'd0 : ws_dec - 4'd1;
               tmo_nxt   = 8'd0;
               cs_l_nxt  = cs_dec;
               op_l_nxt  = IO_Op;
            end
         end
         WAIT: begin
            cs_eff = cs_l;
            op_eff = op_l;
            io_w   = cs_l[2] & Wait_In;
            if (cnt != 4'd0)
               cnt_nxt = cnt - 4'd1;
            if (io_w)
               tmo_nxt = tmo + 8'd1;
            // Watchdog forces completion of a hung IO cycle
            if (io_w && tmo == TMO) begin
               rdy_c     = 1'b1;
               err_set   = 1'b1;
               state_nxt = IDLE;
            end else if (cnt == 4'd0 && !io_w) begin
               rdy_c     = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         tmo    <= 8'd0;
         cs_l   <= 3'b000;
         op_l   <= 2'b00;
         DI     <= 8'h00;
         BusErr <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         tmo   <= tmo_nxt;
         cs_l  <= cs_l_nxt;
         op_l  <= op_l_nxt;
         if (rdy_c && op_eff[1])
            DI <= MD_I;
         if (err_set)
            BusErr <= 1'b1;
      end
   end

   assign cs_act = (!Rst && op_eff != 2'b00) ? cs_eff : 3'b000;
   assign nCS    = ~cs_act;
   assign nRD    = ~(!Rst && op_eff[1]);
   assign nWR    = ~(!Rst && op_eff == 2'b01);
   assign Rdy    = rdy_c & ~Rst;
   assign MA     = AO;
   assign MD_O   = DO;

endmodule
